// File: rtl/chunked_subtractor.sv
// Multi-cycle subtractor: a - b - borrow, one CHUNK-bit slice per clock, LSB slice first,
// with start/ready request and valid/ready result handshakes.
module chunked_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             ready_out,
  output logic             result_valid_out,
  input  logic             result_ready_in,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             zero_out,
  output logic             negative_out,
  output logic             overflow_out
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic [CHUNK:0]   slice_res;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_out_q;
  logic             zero_q;
  logic             negative_q;
  logic             overflow_q;

  // Operands shift right each slice so the active slice is always bits [CHUNK-1:0];
  // the accumulator fills from the top so it is aligned after the last slice.
  always_comb begin
    slice_res = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - {{CHUNK{1'b0}}, borrow_q};
    acc_d = acc_q >> CHUNK;
    acc_d[WIDTH-1 -: CHUNK] = slice_res[CHUNK-1:0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
      negative_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            a_q      <= a_in;
            b_q      <= b_in;
            a_msb_q  <= a_in[WIDTH-1];
            b_msb_q  <= b_in[WIDTH-1];
            borrow_q <= borrow_in;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          acc_q    <= acc_d;
          borrow_q <= slice_res[CHUNK];
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == LAST_SLICE) begin
            // Signed overflow from the original operand signs and the final result sign.
            diff_q       <= acc_d;
            borrow_out_q <= slice_res[CHUNK];
            zero_q       <= (acc_d == '0);
            negative_q   <= acc_d[WIDTH-1];
            overflow_q   <= (a_msb_q ^ b_msb_q) & (acc_d[WIDTH-1] ^ a_msb_q);
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (result_ready_in) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_out        = (state_q == IDLE);
  assign result_valid_out = (state_q == DONE);
  assign diff_out         = diff_q;
  assign borrow_out       = borrow_out_q;
  assign zero_out         = zero_q;
  assign negative_out     = negative_q;
  assign overflow_out     = overflow_q;

endmodule

// File: tb/tb_chunked_subtractor.sv
// Directed bench for chunked_subtractor: expected results are queued at request time
// and compared when the result handshake fires.
module tb_chunked_subtractor;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        borrow_in = 1'b0;
  logic        ready_out;
  logic        result_valid_out;
  logic        result_ready_in = 1'b0;
  logic [15:0] diff_out;
  logic        borrow_out;
  logic        zero_out;
  logic        negative_out;
  logic        overflow_out;

  chunked_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .start_in         (start_in),
    .a_in             (a_in),
    .b_in             (b_in),
    .borrow_in        (borrow_in),
    .ready_out        (ready_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .diff_out         (diff_out),
    .borrow_out       (borrow_out),
    .zero_out         (zero_out),
    .negative_out     (negative_out),
    .overflow_out     (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [15:0] diff;
    logic        brw;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [15:0] last_diff = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent full-width reference for a - b - bin.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t        e;
    logic [16:0] full;
    full   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
    e.diff = full[15:0];
    e.brw  = full[16];
    e.zero = (full[15:0] == 16'd0);
    e.neg  = full[15];
    e.ovf  = (a[15] != b[15]) && (full[15] != a[15]);
    return e;
  endfunction

  // Called #1 after a rising edge; the accept happens on the next rising edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
    check("ready_before_accept", ready_out, 1);
    sb_q.push_back(model(a, b, bin));
    a_in = a; b_in = b; borrow_in = bin; start_in = 1'b1;
    @(posedge clk_in); #1;
    start_in = 1'b0;
    check("ready_drop_after_accept", ready_out, 0);
  endtask

  task automatic wait_result(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(posedge clk_in); #1;
      lat++;
      if (!result_valid_out && lat < 20)
        check({tag, "_hold_during_run"}, diff_out, last_diff);
    end while (!result_valid_out && lat < 20);
    check({tag, "_latency"}, lat, 4);
    if (sb_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_diff"},     diff_out,     e.diff);
      check({tag, "_borrow"},   borrow_out,   e.brw);
      check({tag, "_zero"},     zero_out,     e.zero);
      check({tag, "_negative"}, negative_out, e.neg);
      check({tag, "_overflow"}, overflow_out, e.ovf);
      last_diff = e.diff;
    end
  endtask

  task automatic ack(input string tag);
    result_ready_in = 1'b1;
    @(posedge clk_in); #1;
    result_ready_in = 1'b0;
    check({tag, "_valid_after_ack"}, result_valid_out, 0);
    check({tag, "_ready_after_ack"}, ready_out, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    // Reset state
    #12;
    check("rst_ready", ready_out, 1);
    check("rst_valid", result_valid_out, 0);
    check("rst_diff", diff_out, 0);
    check("rst_flags", {borrow_out, zero_out, negative_out, overflow_out}, 0);
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Basic
    start_op(16'h0005, 16'h0003, 1'b0);
    wait_result("basic");
    check("basic_value_const", diff_out, 16'h0002);
    ack("basic");

    // Cross-slice borrow
    @(posedge clk_in); #1;
    start_op(16'h0000, 16'h0001, 1'b0);
    wait_result("xborrow");
    ack("xborrow");

    // Signed overflow
    @(posedge clk_in); #1;
    start_op(16'h8000, 16'h0001, 1'b0);
    wait_result("ovf");
    check("ovf_flag_const", overflow_out, 1);
    ack("ovf");

    // Borrow-in to zero
    @(posedge clk_in); #1;
    start_op(16'h1234, 16'h1233, 1'b1);
    wait_result("bin_zero");
    check("bin_zero_flag_const", zero_out, 1);
    ack("bin_zero");

    // Backpressure with an ignored start
    @(posedge clk_in); #1;
    start_op(16'h0005, 16'h0003, 1'b0);
    wait_result("bp_first");
    a_in = 16'hFFFF; b_in = 16'h0000; borrow_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_in = 1'b1;
      @(posedge clk_in); #1;
      check("bp_diff_stable", diff_out, 16'h0002);
      check("bp_ready_low", ready_out, 0);
      check("bp_valid_high", result_valid_out, 1);
    end
    start_in = 1'b0;
    ack("bp");
    check("bp_diff_held_in_idle", diff_out, 16'h0002);
    check("bp_no_queued_op", sb_q.size(), 0);
    start_op(16'hFFFF, 16'h0000, 1'b0);
    wait_result("bp_next");
    check("bp_next_value_const", diff_out, 16'hFFFF);
    ack("bp_next");

    // Reset in the middle of RUN
    @(posedge clk_in); #1;
    start_op(16'h00F0, 16'h000F, 1'b0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_n_in = 1'b0;
    #1;
    check("midrst_valid", result_valid_out, 0);
    check("midrst_ready", ready_out, 1);
    check("midrst_diff", diff_out, 0);
    check("midrst_flags", {borrow_out, zero_out, negative_out, overflow_out}, 0);
    void'(sb_q.pop_back());
    last_diff = '0;
    @(posedge clk_in); #1;
    check("midrst_no_valid_in_reset", result_valid_out, 0);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    start_op(16'h00F0, 16'h000F, 1'b0);
    wait_result("after_rst");
    check("after_rst_value_const", diff_out, 16'h00E1);
    ack("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/chunked_subtractor.md
# chunked_subtractor

Multi-cycle subtractor that computes `a - b - borrow` over a WIDTH-bit operand pair. It processes one CHUNK-bit slice per clock, least-significant slice first, and ripples a single borrow register between slices. It is the subtract-direction companion to the lookahead adders in the arithmetic library and is intended for the ALU's compare/subtract path, where area matters more than single-cycle latency. Requests are accepted on a start/ready handshake; results are returned on a valid/ready handshake.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be a positive multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- start_in  input  1  request strobe; accepted only when ready_out=1.
- a_in  input  WIDTH  minuend, sampled on the accept edge.
- b_in  input  WIDTH  subtrahend, sampled on the accept edge.
- borrow_in  input  1  initial borrow, sampled on the accept edge.
- ready_out  output  1  high only in IDLE.
- result_valid_out  output  1  high only in DONE.
- result_ready_in  input  1  consumer acknowledge.
- diff_out  output  WIDTH  (a - b - borrow) mod 2^WIDTH.
- borrow_out  output  1  1 when a < b + borrow (unsigned).
- zero_out  output  1  diff_out == 0.
- negative_out  output  1  diff_out[WIDTH-1].
- overflow_out  output  1  signed overflow: a and b signs differ, and the result sign differs from a's sign.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - ready_out=1.
  - start_in=1 latches a_in, b_in and borrow_in into internal registers, clears the slice counter, and moves to RUN.
- RUN:
  - Each cycle subtracts slice k of the latched operands with the borrow register.
  - The slice difference is written into the internal accumulator, and the borrow register is updated.
  - k increments each cycle.
  - On the slice k = N-1 edge, the final values are loaded into diff_out, borrow_out, zero_out, negative_out and overflow_out, and the state moves to DONE.
- DONE:
  - result_valid_out=1.
  - result_ready_in=1 returns the state to IDLE.
- start_in is ignored outside IDLE, with no queuing. This includes the DONE acknowledge cycle, so back-to-back operations need one IDLE cycle between them.
- Result outputs change only on the RUN→DONE edge. They hold the last result through IDLE and through the following RUN until the next completion.
- Overflow uses the latched MSBs of a and b and the final result MSB. It is evaluated for all borrow_in values.
- N=1 (CHUNK=WIDTH) is legal: RUN lasts exactly one cycle.
- Reset, asynchronous at any time including mid-RUN:
  - State goes to IDLE and the operation is abandoned.
  - All result outputs and result_valid_out go to 0; ready_out=1 while rst_n_in is low.
  - No partial result is ever presented.

## Timing
- Accept edge E0 (IDLE, start_in=1): ready_out drops after E0.
- RUN occupies edges E1..EN. result_valid_out and the result outputs become valid immediately after EN. Latency from accept edge to valid is N cycles (4 at defaults).
- DONE holds indefinitely while result_ready_in=0; all outputs must stay stable.
- Acknowledge edge: DONE with result_ready_in=1. After it, result_valid_out=0 and ready_out=1.
- Minimum accept-to-accept spacing: N+2 edges.
- result_ready_in has no effect outside DONE.

## Test plan
- Basic: WIDTH=16, CHUNK=4; a=0x0005, b=0x0003, borrow_in=0.
  - Requires diff=0x0002, borrow/zero/negative/overflow all 0.
  - result_valid_out high exactly 4 cycles after the accept edge.
- Cross-slice borrow: a=0x0000, b=0x0001.
  - Requires diff=0xFFFF, borrow_out=1, negative_out=1, overflow_out=0.
- Signed overflow: a=0x8000, b=0x0001.
  - Requires diff=0x7FFF, overflow_out=1, borrow_out=0, negative_out=0.
- Borrow-in to zero: a=0x1234, b=0x1233, borrow_in=1.
  - Requires diff=0x0000, zero_out=1, borrow_out=0.
- Backpressure: complete the 0x0005-0x0003 operation, then hold result_ready_in=0 for 3 cycles while pulsing start_in with a=0xFFFF, b=0x0000.
  - Requires outputs stable at 0x0002 and ready_out=0 throughout.
  - The start is ignored.
  - After the acknowledge, ready_out=1 and the next accept produces 0xFFFF.
- Reset mid-RUN: accept a=0x00F0, b=0x000F, then drop rst_n_in after 2 RUN edges.
  - Requires immediate result_valid_out=0, ready_out=1, and diff_out=0x0000.
  - After release, a fresh accept of the same operands yields diff_out=0x00E1 in 4 cycles.
